// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// regfile_write_arbiter : round-robin share of the register-file write port
//                         plus per-register in-flight scoreboard for RAW stalls
// Revision 1.0
// ============================================================================
module regfile_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*REG_AW-1:0] req_rd,
    input  logic [NUM_REQ*XLEN-1:0]   req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      alloc_valid,
    input  logic [REG_AW-1:0]         alloc_rd,
    input  logic [REG_AW-1:0]         rs1,
    input  logic [REG_AW-1:0]         rs2,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic                      rf_we,
    output logic [REG_AW-1:0]         rf_rd,
    output logic [XLEN-1:0]           rf_rd_data,
    output logic [(1<<REG_AW)-1:0]    pending
);

    localparam int            PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int            NREG     = 1 << REG_AW;
    localparam logic [PW-1:0] LAST_RST = PW'(NUM_REQ - 1);

    logic [REG_AW-1:0] rd_arr   [NUM_REQ];
    logic [XLEN-1:0]   data_arr [NUM_REQ];

    logic [PW-1:0]     last_q, last_d;
    logic              rf_we_q, rf_we_d;
    logic [REG_AW-1:0] rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]   rf_rd_data_q, rf_rd_data_d;
    logic [NREG-1:0]   pending_q, pending_d;

    logic [PW-1:0]     cand;
    logic [PW-1:0]     grant_idx;
    logic              grant_found;
    logic [REG_AW-1:0] sel_rd;
    logic [XLEN-1:0]   sel_data;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign rd_arr[gi]   = req_rd[gi*REG_AW +: REG_AW];
            assign data_arr[gi] = req_data[gi*XLEN +: XLEN];
        end
    endgenerate

    // Walk last+1, last+2, ... with wrap; first valid requester wins.
    always_comb begin
        grant_idx   = last_q;
        grant_found = 1'b0;
        cand        = last_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (cand == LAST_RST) ? '0 : cand + PW'(1);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign sel_rd   = rd_arr[grant_idx];
    assign sel_data = data_arr[grant_idx];

    always_comb begin
        last_d       = last_q;
        rf_we_d      = 1'b0;
        rf_rd_d      = rf_rd_q;
        rf_rd_data_d = rf_rd_data_q;
        pending_d    = pending_q;
        if (grant_found) begin
            last_d            = grant_idx;
            rf_we_d           = (sel_rd != '0);
            rf_rd_d           = sel_rd;
            rf_rd_data_d      = sel_data;
            pending_d[sel_rd] = 1'b0;
        end
        // Alloc applied after the clear so a new producer on the same register wins.
        if (alloc_valid) begin
            pending_d[alloc_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q       <= LAST_RST;
            rf_we_q      <= 1'b0;
            rf_rd_q      <= '0;
            rf_rd_data_q <= '0;
            pending_q    <= '0;
        end else begin
            last_q       <= last_d;
            rf_we_q      <= rf_we_d;
            rf_rd_q      <= rf_rd_d;
            rf_rd_data_q <= rf_rd_data_d;
            pending_q    <= pending_d;
        end
    end

    // The output-stage term covers the cycle before register_file commits (no bypass).
    assign rs1_busy = (rs1 != '0) && (pending_q[rs1] || (rf_we_q && (rf_rd_q == rs1)));
    assign rs2_busy = (rs2 != '0) && (pending_q[rs2] || (rf_we_q && (rf_rd_q == rs2)));

    assign rf_we      = rf_we_q;
    assign rf_rd      = rf_rd_q;
    assign rf_rd_data = rf_rd_data_q;
    assign pending    = pending_q;

endmodule
`default_nettype wire
